// File: rtl/ysyx_24090003_lsu_ctrl.sv
// ysyx_24090003_lsu_ctrl: sequential load/store unit, one outstanding access.
// Steers store data/strobes onto byte lanes, extracts and extends load data,
// and reports misaligned/illegal accesses without touching the bus.
// Optional watchdog: define YSYX_24090003_LSU_TIMEOUT_EN to abort accesses
// whose memory response does not arrive within TO_CYC cycles.
module ysyx_24090003_lsu_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TO_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [XLEN-1:0]   o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  output logic              o_mem_we,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_mem_err
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [OFF_W-1:0] off_q;
  logic [1:0]       size_q;
  logic             we_q;
  logic             uns_q;

  logic [OFF_W-1:0]  req_off_c;
  logic              req_bad_c;
  logic [STRB_W-1:0] strb_base_c;
  logic [STRB_W-1:0] req_strb_c;
  logic [XLEN-1:0]   req_wdata_c;
  logic [XLEN-1:0]   shifted_c;
  logic [XLEN-1:0]   ext_c;
  logic              rsp_fire_c;

`ifdef YSYX_24090003_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt;
`else
  logic unused_to;
  assign unused_to = (TO_CYC != 0);
`endif

  // Request decode: lane offset, alignment check, lane-steered strobes and data
  always_comb begin
    req_off_c   = i_req_addr[OFF_W-1:0];
    req_wdata_c = i_req_wdata << {req_off_c, 3'b000};
    case (i_req_size)
      2'b00: begin
        req_bad_c   = 1'b0;
        strb_base_c = STRB_W'(1);
      end
      2'b01: begin
        req_bad_c   = i_req_addr[0];
        strb_base_c = STRB_W'(2'b11);
      end
      2'b10: begin
        req_bad_c   = |i_req_addr[1:0];
        strb_base_c = STRB_W'(4'hF);
      end
      default: begin
        req_bad_c   = (XLEN == 32) || (|i_req_addr[2:0]);
        strb_base_c = STRB_W'(8'hFF);
      end
    endcase
    req_strb_c = strb_base_c << req_off_c;
  end

  // Response decode: shift the addressed lanes down and extend to XLEN
  always_comb begin
    shifted_c = i_mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ext_c = uns_q ? XLEN'(shifted_c[7:0])  : XLEN'($signed(shifted_c[7:0]));
      2'b01:   ext_c = uns_q ? XLEN'(shifted_c[15:0]) : XLEN'($signed(shifted_c[15:0]));
      2'b10:   ext_c = uns_q ? XLEN'(shifted_c[31:0]) : XLEN'($signed(shifted_c[31:0]));
      default: ext_c = shifted_c;
    endcase
    if (we_q) ext_c = '0;
    rsp_fire_c = i_mem_rsp_valid && ((state == WAIT) || ((state == REQ) && i_mem_ready));
  end

  // Access FSM with registered request, memory and response outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
      o_mem_valid  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_wstrb  <= '0;
      o_mem_we     <= 1'b0;
`ifdef YSYX_24090003_LSU_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            off_q       <= req_off_c;
            size_q      <= i_req_size;
            we_q        <= i_req_we;
            uns_q       <= i_req_unsigned;
            o_req_ready <= 1'b0;
            if (req_bad_c) begin
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_rdata <= '0;
              state        <= RESP;
            end else begin
              o_mem_valid <= 1'b1;
              o_mem_addr  <= {i_req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              o_mem_wdata <= req_wdata_c;
              o_mem_wstrb <= i_req_we ? req_strb_c : '0;
              o_mem_we    <= i_req_we;
              state       <= REQ;
`ifdef YSYX_24090003_LSU_TIMEOUT_EN
              cnt         <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            o_req_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: ;
      endcase

      // Memory response (possibly in the same cycle as the request handshake)
      if (rsp_fire_c) begin
        o_resp_valid <= 1'b1;
        o_resp_rdata <= ext_c;
        o_resp_err   <= i_mem_err;
        state        <= RESP;
      end

`ifdef YSYX_24090003_LSU_TIMEOUT_EN
      // Watchdog: abort the access once TO_CYC cycles pass without a response
      if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + CNT_W'(1);
        if (!rsp_fire_c && (cnt == CNT_W'(TO_CYC - 1))) begin
          o_mem_valid  <= 1'b0;
          o_resp_valid <= 1'b1;
          o_resp_err   <= 1'b1;
          o_resp_rdata <= '0;
          state        <= RESP;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_lsu_ctrl.sv
// Testbench for ysyx_24090003_lsu_ctrl (XLEN = 32): directed cases plus
// randomized transactions checked against a transaction-level model.
module tb_ysyx_24090003_lsu_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = '0;
  logic              req_unsigned = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              mem_we;
  logic              mem_rsp_valid = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              mem_err = 1'b0;

  int total = 0;
  int bad   = 0;

  ysyx_24090003_lsu_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TO_CYC(255)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_we(req_we), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .o_mem_we(mem_we),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rdata(mem_rdata), .i_mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full access. mdly: cycles memory holds ready low; rdly: cycles after
  // the request handshake until the response (0 = same cycle); cdly: cycles
  // the core holds resp_ready low.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] rdata, input logic err,
                         input int mdly, input int rdly, input int cdly);
    int          off;
    int          nb;
    logic        acc_bad;
    logic [63:0] mask;
    logic [63:0] v;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rd;
    logic        exp_err;

    off      = int'(addr % 4);
    nb       = 1 << size;
    acc_bad  = (size == 2'd3) || ((addr % nb) != 0);
    mask     = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    exp_addr = addr - (addr % 4);
    exp_wd   = 32'((64'(wdata) << (8 * off)) & 64'hFFFF_FFFF);
    exp_strb = we ? 4'((((64'd1 << nb) - 64'd1) << off) & 64'hF) : 4'h0;
    v        = (64'(rdata) >> (8 * off)) & mask;
    if (!uns && v[8 * nb - 1]) v = v | ~mask;
    exp_rd   = we ? 32'h0 : v[31:0];
    exp_err  = err;
    if (acc_bad) begin
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wdata    = wdata;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;

    if (acc_bad) begin
      check("bad_no_mem_valid", 64'(mem_valid), 64'd0);
    end else begin
      for (int i = 0; i <= mdly; i++) begin
        check("mem_valid", 64'(mem_valid), 64'd1);
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(exp_wd));
        check("mem_wstrb", 64'(mem_wstrb), 64'(exp_strb));
        check("mem_we", 64'(mem_we), 64'(we));
        check("req_ready_busy", 64'(req_ready), 64'd0);
        check("resp_valid_early", 64'(resp_valid), 64'd0);
        if (i == mdly) begin
          mem_ready = 1'b1;
          if (rdly == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = rdata;
            mem_err       = err;
          end
        end
        step();
      end
      mem_ready     = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_err       = 1'b0;
      mem_rdata     = $urandom;
      for (int i = 0; i < rdly; i++) begin
        check("wait_mem_valid", 64'(mem_valid), 64'd0);
        check("wait_resp_valid", 64'(resp_valid), 64'd0);
        if (i == rdly - 1) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = rdata;
          mem_err       = err;
        end
        step();
      end
      mem_rsp_valid = 1'b0;
      mem_err       = 1'b0;
      mem_rdata     = $urandom;
    end

    for (int i = 0; i <= cdly; i++) begin
      check("resp_valid", 64'(resp_valid), 64'd1);
      check("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
      check("resp_err", 64'(resp_err), 64'(exp_err));
      check("resp_req_ready", 64'(req_ready), 64'd0);
      check("resp_mem_valid", 64'(mem_valid), 64'd0);
      if (i == cdly) resp_ready = 1'b1;
      step();
    end
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    rst = 1'b0;
    step();

    // lb, sh, misaligned lw, back-pressure, bus error on lhu
    run_txn(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 0, 0, 0);
    run_txn(32'h8000_0002, 32'h0000_ABCD, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 0, 1, 0);
    run_txn(32'h8000_0001, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 0, 0, 0);
    run_txn(32'h0000_0104, 32'h1234_5678, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 3, 0, 2);
    run_txn(32'h0000_0010, 32'h0, 1'b0, 2'd1, 1'b1, 32'hFFFF_8001, 1'b1, 0, 2, 0);
    run_txn(32'h0000_0020, 32'h0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0, 0, 0, 1);
    run_txn(32'h0000_0022, 32'h0, 1'b0, 2'd1, 1'b0, 32'h8001_7FFF, 1'b0, 1, 1, 1);

    // randomized accesses
    for (int n = 0; n < 150; n++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(a, $urandom, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // asynchronous reset while waiting for the memory response
    req_valid = 1'b1;
    req_addr  = 32'h0000_0040;
    req_we    = 1'b0;
    req_size  = 2'd2;
    step();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("wait_before_rst", 64'(resp_valid), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_mem_valid", 64'(mem_valid), 64'd0);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_mem_addr", 64'(mem_addr), 64'd0);
    check("arst_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_txn(32'h0000_0046, 32'h0, 1'b0, 2'd1, 1'b0, 32'h9ABC_0000, 1'b0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_lsu_ctrl.md
Name: ysyx_24090003_lsu_ctrl

Overview:
- Sequential load/store unit between EXU and the memory bus; one outstanding access.
- Accepts a request over a valid/ready handshake and drives a lane-aligned memory request with byte strobes.
- Waits for the memory response, then returns sign/zero-extended read data or an error to the core.
- Generalises the combinational LSU: parametrised data width, address-offset lane steering, misalignment detection and response buffering.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- TO_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  LSU can accept a request
- i_req_addr  in  ADDR_W  byte address
- i_req_wdata  in  XLEN  store data, right-justified
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword
- i_req_unsigned  in  1  zero-extend load result
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  core accepts the response
- o_resp_rdata  out  XLEN  extended load data; 0 for stores
- o_resp_err  out  1  misaligned access, illegal size, bus error or timeout
- o_mem_valid  out  1  memory request valid
- i_mem_ready  in  1  memory accepts the request
- o_mem_addr  out  ADDR_W  address aligned to XLEN/8
- o_mem_wdata  out  XLEN  store data shifted to its byte lanes
- o_mem_wstrb  out  XLEN/8  byte write strobes; all 0 for loads
- o_mem_we  out  1  write enable
- i_mem_rsp_valid  in  1  memory response (read data or write ack)
- i_mem_rdata  in  XLEN  full-width read data
- i_mem_err  in  1  bus error; qualified by i_mem_rsp_valid

Behaviour:
- Reset: all outputs 0 except o_req_ready = 1; state IDLE. Reset mid-transaction abandons it; the memory side is reset at the same time.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid: latch addr, wdata, we, size, unsigned.
  - off = addr[log2(XLEN/8)-1:0].
  - If (addr mod (1<<size)) != 0, or size = 11 with XLEN = 32: go to RESP with err = 1, rdata = 0, no memory request issued.
  - Otherwise go to REQ.
- REQ:
  - o_mem_valid = 1; o_mem_addr = addr with low offset bits cleared.
  - o_mem_wstrb = ((1 << (1 << size)) - 1) << off when storing.
  - o_mem_wdata = wdata << (8*off).
  - All memory outputs are held stable until i_mem_ready; on i_mem_valid && i_mem_ready go to WAIT.
  - A response arriving in the same cycle as ready is legal and is handled as in WAIT.
- WAIT:
  - On i_mem_rsp_valid: shift = i_mem_rdata >> (8*off); take the low 8/16/32/64 bits; sign-extend unless unsigned or dword.
  - Register the extended data into o_resp_rdata (0 for stores) and o_resp_err = i_mem_err; go to RESP.
- RESP:
  - o_resp_valid = 1 with stable data until i_resp_ready; then go to IDLE.
  - o_resp_valid drops in the cycle after the handshake.
  - A new request is accepted one cycle after the response handshake; no overlap.
- Minimum latency: accept at T, o_mem_valid at T+1, zero-wait memory response at T+1, o_resp_valid at T+2.
- Word loads with XLEN = 32 ignore i_req_unsigned.

Optional Feature:
- Macro: YSYX_24090003_LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TO_CYC: go to RESP with err = 1 and rdata = 0; o_mem_valid drops.
  - A late i_mem_rsp_valid for that access is ignored, but only while the FSM is in IDLE or RESP.
- Undefined: no counter; the LSU waits indefinitely.

Test Plan:
- lb at addr 0x8000_0003, mem rdata 0x80FF_1234 (XLEN = 32) -> o_mem_addr 0x8000_0000, wstrb 0000, resp rdata 0xFFFF_FF80, err 0.
- sh at addr 0x8000_0002, wdata 0x0000_ABCD -> o_mem_wdata 0xABCD_0000, wstrb 1100, resp err 0, rdata 0.
- lw at addr 0x8000_0001 -> no o_mem_valid ever asserted, resp err 1 at T+1.
- Back-pressure: i_mem_ready low for 3 cycles, i_resp_ready low for 2 cycles -> memory outputs and response held stable; o_req_ready stays 0 throughout.
- i_mem_err = 1 on an lhu at 0x10 -> resp err 1; next request accepted after the response handshake.
- With YSYX_24090003_LSU_TIMEOUT_EN and TO_CYC = 4, memory never responds -> resp err 1 exactly 4 cycles after entering REQ. Async reset asserted in WAIT -> all outputs 0 and o_req_ready 1 immediately.
